// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI-side register bank with burst auto-increment, ID register,
// sticky error flag and saturating write counter.
module spi_reg_bank #(
   parameter int              WIDTH    = 8,
   parameter int              DEPTH    = 256,
   parameter logic [WIDTH-1:0] ID_VALUE = 8'hA5
) (
   input  logic             SCLK,
   input  logic             RST,
   input  logic             SS,
   input  logic             Wr_EN,
   input  logic             Rd_EN,
   input  logic [WIDTH-1:0] Address,
   input  logic [WIDTH-1:0] Wr_Data,
   output logic [WIDTH-1:0] Rd_Data,
   output logic             Busy,
   output logic             Err,
   output logic [7:0]       Wr_Count
);

   localparam logic [WIDTH-1:0] LAST    = WIDTH'(DEPTH - 1);
   localparam logic [WIDTH:0]   DEPTH_W = (WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ADDR_WAIT, WR_BURST, RD_BURST} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] ptr;
   logic             wr_q, rd_q;
   logic             ss_armed;

   logic             wr_ev, rd_ev, both_ev;
   logic             do_wr, do_rd, err_set;
   logic [WIDTH-1:0] acc_addr;
   logic             addr_oob, wr_bad;

   function automatic logic [WIDTH-1:0] next_ptr(input logic [WIDTH-1:0] a);
      return (a == LAST) ? '0 : a + 1'b1;
   endfunction

   assign wr_ev    = Wr_EN & ~wr_q;
   assign rd_ev    = Rd_EN & ~rd_q;
   assign both_ev  = wr_ev & rd_ev;
   assign addr_oob = ({1'b0, acc_addr} >= DEPTH_W);
   assign wr_bad   = (acc_addr == '0) | addr_oob;

   always_ff @(posedge SCLK) begin
      if (!RST) state <= IDLE;
      else      state <= state_n;
   end

   // A frame only opens after SS has been seen high since reset, so a reset
   // in the middle of a frame cannot resume with a stale address.
   always_comb begin
      state_n = state;
      if (SS) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:      if (ss_armed) state_n = ADDR_WAIT;
            ADDR_WAIT: begin
               if (!both_ev) begin
                  if (wr_ev)      state_n = WR_BURST;
                  else if (rd_ev) state_n = RD_BURST;
               end
            end
            default:   state_n = state;
         endcase
      end
   end

   always_comb begin
      do_wr    = 1'b0;
      do_rd    = 1'b0;
      err_set  = 1'b0;
      acc_addr = ptr;
      Busy     = (state == WR_BURST) || (state == RD_BURST);
      if (!SS) begin
         case (state)
            ADDR_WAIT: begin
               acc_addr = Address;
               if (both_ev)    err_set = 1'b1;
               else if (wr_ev) do_wr   = 1'b1;
               else if (rd_ev) do_rd   = 1'b1;
            end
            WR_BURST: begin
               if (both_ev)    err_set = 1'b1;
               else if (wr_ev) do_wr   = 1'b1;
               else if (rd_ev) err_set = 1'b1;
            end
            RD_BURST: begin
               if (both_ev)    err_set = 1'b1;
               else if (rd_ev) do_rd   = 1'b1;
               else if (wr_ev) err_set = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge SCLK) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         Rd_Data  <= '0;
         Err      <= 1'b0;
         Wr_Count <= 8'd0;
         ptr      <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         ss_armed <= 1'b0;
      end else begin
         wr_q <= Wr_EN;
         rd_q <= Rd_EN;
         if (SS) ss_armed <= 1'b1;

         if (SS)                 ptr <= '0;
         else if (do_wr | do_rd) ptr <= next_ptr(acc_addr);

         if (err_set || (do_wr && wr_bad) || (do_rd && addr_oob)) Err <= 1'b1;

         if (do_wr && !wr_bad) begin
            mem[acc_addr] <= Wr_Data;
            if (Wr_Count != 8'hFF) Wr_Count <= Wr_Count + 8'd1;
         end

         if (do_rd) begin
            if (acc_addr == '0)  Rd_Data <= ID_VALUE;
            else if (addr_oob)   Rd_Data <= '0;
            else                 Rd_Data <= mem[acc_addr];
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - directed self-checking bench for spi_reg_bank.
module tb_spi_reg_bank;

   logic       SCLK = 1'b0;
   logic       RST, SS, Wr_EN, Rd_EN;
   logic [7:0] Address, Wr_Data, Rd_Data, Wr_Count;
   logic       Busy, Err;

   int errors = 0;
   int checks = 0;

   spi_reg_bank dut (
      .SCLK(SCLK), .RST(RST), .SS(SS), .Wr_EN(Wr_EN), .Rd_EN(Rd_EN),
      .Address(Address), .Wr_Data(Wr_Data), .Rd_Data(Rd_Data),
      .Busy(Busy), .Err(Err), .Wr_Count(Wr_Count)
   );

   always #5 SCLK = ~SCLK;

   task automatic tick;
      @(posedge SCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset;
      RST = 1'b0; SS = 1'b1; Wr_EN = 1'b0; Rd_EN = 1'b0;
      tick;
      RST = 1'b1;
      tick;
   endtask

   task automatic frame_start(input logic [7:0] addr);
      SS = 1'b0; Address = addr;
      tick;
      tick;
   endtask

   task automatic frame_end;
      SS = 1'b1;
      tick;
   endtask

   task automatic wr_pulse(input logic [7:0] data);
      Wr_Data = data; Wr_EN = 1'b1;
      tick;
      Wr_EN = 1'b0;
      tick;
   endtask

   task automatic rd_pulse(input string tag, input logic [7:0] exp);
      Rd_EN = 1'b1;
      tick;
      chk(tag, 32'(Rd_Data), 32'(exp));
      Rd_EN = 1'b0;
      tick;
   endtask

   initial begin
      logic [7:0] burst [5];
      burst[0] = 8'h1B; burst[1] = 8'hCA; burst[2] = 8'h52;
      burst[3] = 8'hCA; burst[4] = 8'h1E;
      Address = 8'h00; Wr_Data = 8'h00;

      do_reset;
      chk("reset_rd_data", 32'(Rd_Data), 32'h0);
      chk("reset_busy", 32'(Busy), 32'h0);
      chk("reset_err", 32'(Err), 32'h0);
      chk("reset_wr_count", 32'(Wr_Count), 32'h0);

      // single write
      frame_start(8'h35);
      wr_pulse(8'h1B);
      chk("single_busy", 32'(Busy), 32'h1);
      frame_end;
      chk("single_busy_end", 32'(Busy), 32'h0);
      chk("single_count", 32'(Wr_Count), 32'h1);
      chk("single_err", 32'(Err), 32'h0);

      // burst write then burst read
      do_reset;
      frame_start(8'h35);
      for (int i = 0; i < 5; i++) wr_pulse(burst[i]);
      chk("burst_wr_busy", 32'(Busy), 32'h1);
      frame_end;
      chk("burst_wr_busy_end", 32'(Busy), 32'h0);
      chk("burst_wr_count", 32'(Wr_Count), 32'h5);
      frame_start(8'h35);
      for (int i = 0; i < 5; i++) rd_pulse($sformatf("burst_rd_%0d", i), burst[i]);
      chk("burst_rd_busy", 32'(Busy), 32'h1);
      frame_end;
      chk("burst_rd_err", 32'(Err), 32'h0);

      // read strobe inside a write frame
      frame_start(8'h40);
      wr_pulse(8'h77);
      rd_pulse("wrong_mode_rd_hold", 8'h1E);
      chk("wrong_mode_err", 32'(Err), 32'h1);
      frame_end;
      chk("wrong_mode_count", 32'(Wr_Count), 32'h6);

      // simultaneous strobes in ADDR_WAIT, then a held write strobe
      do_reset;
      frame_start(8'h50);
      Wr_Data = 8'h99; Wr_EN = 1'b1; Rd_EN = 1'b1;
      tick;
      Wr_EN = 1'b0; Rd_EN = 1'b0;
      tick;
      chk("both_err", 32'(Err), 32'h1);
      chk("both_count", 32'(Wr_Count), 32'h0);
      chk("both_busy", 32'(Busy), 32'h0);
      Wr_Data = 8'h66; Wr_EN = 1'b1;
      repeat (4) tick;
      Wr_EN = 1'b0;
      tick;
      chk("held_count", 32'(Wr_Count), 32'h1);
      chk("held_busy", 32'(Busy), 32'h1);
      frame_end;
      frame_start(8'h50);
      rd_pulse("held_rd_50", 8'h66);
      rd_pulse("held_rd_51", 8'h00);
      frame_end;

      // wrap past the top and ID register
      do_reset;
      frame_start(8'hFF);
      wr_pulse(8'h11);
      chk("wrap_err_before", 32'(Err), 32'h0);
      wr_pulse(8'h22);
      chk("wrap_err", 32'(Err), 32'h1);
      chk("wrap_count", 32'(Wr_Count), 32'h1);
      frame_end;
      frame_start(8'h00);
      rd_pulse("id_read", 8'hA5);
      rd_pulse("after_id_read", 8'h00);
      frame_end;
      frame_start(8'hFF);
      rd_pulse("wrap_rd_ff", 8'h11);
      rd_pulse("wrap_rd_00", 8'hA5);
      frame_end;

      // reset in the middle of a burst
      do_reset;
      frame_start(8'h35);
      wr_pulse(8'h1B);
      wr_pulse(8'hCA);
      chk("mid_count_pre", 32'(Wr_Count), 32'h2);
      RST = 1'b0;
      tick;
      RST = 1'b1;
      tick;
      chk("mid_count", 32'(Wr_Count), 32'h0);
      chk("mid_err", 32'(Err), 32'h0);
      chk("mid_busy", 32'(Busy), 32'h0);
      wr_pulse(8'h99);
      wr_pulse(8'h98);
      chk("mid_ignored_count", 32'(Wr_Count), 32'h0);
      chk("mid_ignored_busy", 32'(Busy), 32'h0);
      frame_end;
      frame_start(8'h00);
      rd_pulse("mid_id", 8'hA5);
      frame_end;
      frame_start(8'h35);
      rd_pulse("mid_rd_35", 8'h00);
      rd_pulse("mid_rd_36", 8'h00);
      frame_end;
      chk("mid_err_end", 32'(Err), 32'h0);

      // write counter saturation: 255 good writes at 1..FF, reject at 0, one more good
      do_reset;
      frame_start(8'h01);
      for (int i = 1; i < 256; i++) wr_pulse(8'(i));
      chk("sat_count_255", 32'(Wr_Count), 32'hFF);
      chk("sat_err_clean", 32'(Err), 32'h0);
      wr_pulse(8'hEE);
      wr_pulse(8'hEF);
      chk("sat_count_hold", 32'(Wr_Count), 32'hFF);
      chk("sat_err", 32'(Err), 32'h1);
      frame_end;
      frame_start(8'h01);
      rd_pulse("sat_rd_01", 8'hEF);
      rd_pulse("sat_rd_02", 8'h02);
      frame_end;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
